// File: rtl/uart_rx_core_if.sv
// rtl/uart_rx_core_if.sv - received-byte valid/ready stream between uart_rx_core and the RX FIFO
interface uart_rx_core_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 16x oversampled 8N1 UART receiver with majority vote and byte stream output
module uart_rx_core #(
  parameter int baudrate = 9600,
  parameter int clk_frec = 100000000
) (
  input  logic               S_AXI_ACLK,
  input  logic               S_AXI_ARESETN,
  input  logic               rx,
  uart_rx_core_if.master     m,
  output logic               frame_err,
  output logic               overrun_err,
  output logic               busy
);
  localparam int DIV = clk_frec / (baudrate * 16);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  localparam logic [2:0] WAIT_IDLE = 3'd0;
  localparam logic [2:0] IDLE      = 3'd1;
  localparam logic [2:0] START     = 3'd2;
  localparam logic [2:0] DATA      = 3'd3;
  localparam logic [2:0] STOP      = 3'd4;

  logic          rx_meta, rx_s;
  logic [1:0]    prime;
  logic [CW-1:0] cnt;
  logic [3:0]    s;
  logic          smp7, smp8;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [2:0]    state, state_nxt;
  logic          tick, at_mid, maj, start_det;
  logic          deliver, ferr;

  // prime fills two cycles after reset so WAIT_IDLE ignores the synchronizer's reset value of 1
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      prime   <= 2'b00;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      prime   <= {prime[0], 1'b1};
    end
  end

  assign tick      = (cnt == DIV_LAST);
  assign at_mid    = tick && (s == 4'd9);
  assign maj       = (smp7 & smp8) | (smp7 & rx_s) | (smp8 & rx_s);
  assign start_det = (state == IDLE) && !rx_s;

  always_comb begin
    state_nxt = state;
    deliver   = 1'b0;
    ferr      = 1'b0;
    case (state)
      WAIT_IDLE: if (prime[1] && rx_s) state_nxt = IDLE;
      IDLE:      if (!rx_s) state_nxt = START;
      START:     if (at_mid) state_nxt = maj ? IDLE : DATA;
      DATA:      if (at_mid && bit_idx == 3'd7) state_nxt = STOP;
      STOP: begin
        if (at_mid) begin
          if (maj) begin
            deliver   = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr      = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end
      end
      default:   state_nxt = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state   <= WAIT_IDLE;
      cnt     <= '0;
      s       <= 4'd0;
      smp7    <= 1'b1;
      smp8    <= 1'b1;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
    end else begin
      state <= state_nxt;
      if (start_det || tick) cnt <= '0;
      else                   cnt <= cnt + 1'b1;
      if (start_det)         s <= 4'd0;
      else if (tick)         s <= s + 4'd1;
      if (tick && s == 4'd7) smp7 <= rx_s;
      if (tick && s == 4'd8) smp8 <= rx_s;
      if (start_det) bit_idx <= 3'd0;
      if (state == DATA && at_mid) begin
        shreg   <= {maj, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  // A byte is accepted if the slot is empty or is being drained this very cycle
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      m.m_data    <= 8'h00;
      m.m_valid   <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_err   <= ferr;
      overrun_err <= 1'b0;
      busy        <= (state_nxt != IDLE);
      if (deliver && (!m.m_valid || m.m_ready)) begin
        m.m_data  <= shreg;
        m.m_valid <= 1'b1;
      end else if (deliver) begin
        overrun_err <= 1'b1;
      end else if (m.m_valid && m.m_ready) begin
        m.m_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - scoreboard bench for uart_rx_core
module tb_uart_rx_core;
  localparam int BAUD = 9600;
  localparam int CLKF = 460800;
  localparam int DIV  = 3;
  localparam int BIT  = DIV * 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic frame_err, overrun_err, busy;

  uart_rx_core_if bus();

  uart_rx_core #(.baudrate(BAUD), .clk_frec(CLKF)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .rx(rx), .m(bus),
    .frame_err(frame_err), .overrun_err(overrun_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int fe_hi = 0, fe_rise = 0, ov_hi = 0, ov_rise = 0, v_rise = 0;
  logic fe_d = 1'b0, ov_d = 1'b0, v_d = 1'b0;

  always @(negedge clk) begin
    if (bus.m_valid && bus.m_ready) obs_q.push_back(bus.m_data);
    if (frame_err) fe_hi <= fe_hi + 1;
    if (frame_err && !fe_d) fe_rise <= fe_rise + 1;
    if (overrun_err) ov_hi <= ov_hi + 1;
    if (overrun_err && !ov_d) ov_rise <= ov_rise + 1;
    if (bus.m_valid && !v_d) v_rise <= v_rise + 1;
    fe_d <= frame_err;
    ov_d <= overrun_err;
    v_d  <= bus.m_valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(b[i], BIT);
    drive(stop, BIT);
  endtask

  task automatic wait_obs(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 8 * BIT; c++) begin
      if (obs_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rx = 1'b1;
    bus.m_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (bus.m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", bus.m_valid); end
    n_cmp++; if (bus.m_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", bus.m_data); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    n_cmp++; if (overrun_err !== 1'b0) begin n_bad++; $display("FAIL reset_overrun got %b want 0", overrun_err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
    drive(1'b1, 2 * BIT);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_single;
    int fe0, ov0, v0;
    bit ok;
    logic [7:0] e, o;
    fe0 = fe_rise; ov0 = ov_rise; v0 = v_rise;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    drive(1'b1, BIT);
    wait_obs(1, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_timeout got %0d bytes want 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL single_data got %h want %h", o, e); end
    end
    n_cmp++; if (v_rise - v0 !== 1) begin n_bad++; $display("FAIL single_valid_pulses got %0d want 1", v_rise - v0); end
    n_cmp++; if (fe_rise - fe0 !== 0) begin n_bad++; $display("FAIL single_frame_err got %0d want 0", fe_rise - fe0); end
    n_cmp++; if (ov_rise - ov0 !== 0) begin n_bad++; $display("FAIL single_overrun got %0d want 0", ov_rise - ov0); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy got %b want 0", busy); end
    n_cmp++; if (bus.m_valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_low got %b want 0", bus.m_valid); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back;
    int fe0, ov0, got;
    bit ok;
    logic [7:0] e, o;
    fe0 = fe_rise; ov0 = ov_rise;
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(8'(8'h64 + i));
      send_frame(8'(8'h64 + i), 1'b1);
    end
    drive(1'b1, BIT);
    wait_obs(64, ok);
    n_cmp++; if (!ok || obs_q.size() != 64) begin n_bad++; $display("FAIL b2b_count got %0d want 64", obs_q.size()); end
    got = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL b2b_data[%0d] got %h want %h", got, o, e); end
      got++;
    end
    n_cmp++; if (fe_rise - fe0 !== 0) begin n_bad++; $display("FAIL b2b_frame_err got %0d want 0", fe_rise - fe0); end
    n_cmp++; if (ov_rise - ov0 !== 0) begin n_bad++; $display("FAIL b2b_overrun got %0d want 0", ov_rise - ov0); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_glitch;
    int fe0, v0;
    fe0 = fe_rise; v0 = v_rise;
    drive(1'b0, 3 * DIV);
    drive(1'b1, 2 * BIT);
    n_cmp++; if (v_rise - v0 !== 0) begin n_bad++; $display("FAIL glitch_valid got %0d want 0", v_rise - v0); end
    n_cmp++; if (fe_rise - fe0 !== 0) begin n_bad++; $display("FAIL glitch_frame_err got %0d want 0", fe_rise - fe0); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy got %b want 0", busy); end
  endtask

  task automatic test_framing;
    int fe0, fh0, v0;
    bit ok;
    logic [7:0] e, o;
    fe0 = fe_rise; fh0 = fe_hi; v0 = v_rise;
    send_frame(8'h3C, 1'b0);
    drive(1'b0, 3 * BIT);
    drive(1'b1, 2 * BIT);
    n_cmp++; if (fe_rise - fe0 !== 1) begin n_bad++; $display("FAIL framing_pulses got %0d want 1", fe_rise - fe0); end
    n_cmp++; if (fe_hi - fh0 !== 1) begin n_bad++; $display("FAIL framing_width got %0d want 1", fe_hi - fh0); end
    n_cmp++; if (v_rise - v0 !== 0) begin n_bad++; $display("FAIL framing_valid got %0d want 0", v_rise - v0); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL framing_busy got %b want 0", busy); end
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    drive(1'b1, BIT);
    wait_obs(1, ok);
    n_cmp++; if (!ok || obs_q.size() != 1) begin n_bad++; $display("FAIL framing_recover_count got %0d want 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL framing_recover_data got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_overrun;
    int ov0, oh0, fe0;
    bit ok;
    logic [7:0] e, o;
    ov0 = ov_rise; oh0 = ov_hi; fe0 = fe_rise;
    bus.m_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    drive(1'b1, BIT);
    n_cmp++; if (bus.m_valid !== 1'b1) begin n_bad++; $display("FAIL overrun_valid got %b want 1", bus.m_valid); end
    n_cmp++; if (bus.m_data !== 8'h11) begin n_bad++; $display("FAIL overrun_data_held got %h want 11", bus.m_data); end
    n_cmp++; if (ov_rise - ov0 !== 1) begin n_bad++; $display("FAIL overrun_pulses got %0d want 1", ov_rise - ov0); end
    n_cmp++; if (ov_hi - oh0 !== 1) begin n_bad++; $display("FAIL overrun_width got %0d want 1", ov_hi - oh0); end
    n_cmp++; if (fe_rise - fe0 !== 0) begin n_bad++; $display("FAIL overrun_frame_err got %0d want 0", fe_rise - fe0); end
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL overrun_early_transfer got %0d want 0", obs_q.size()); end
    exp_q.push_back(8'h11);
    bus.m_ready = 1'b1;
    wait_obs(1, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL overrun_drain_timeout got %0d want 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL overrun_drain_data got %h want %h", o, e); end
    end
    drive(1'b1, 4);
    n_cmp++; if (bus.m_valid !== 1'b0) begin n_bad++; $display("FAIL overrun_valid_fall got %b want 0", bus.m_valid); end
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL overrun_extra_transfer got %0d want 0", obs_q.size()); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_midframe;
    int fe0, v0;
    bit ok;
    logic [7:0] e, o;
    fe0 = fe_rise; v0 = v_rise;
    fork
      send_frame(8'h96, 1'b1);
      begin
        repeat (5 * BIT + BIT / 2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy got %b want 0", busy); end
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_valid got %b want 0", bus.m_valid); end
        repeat (BIT - 3) @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
    join
    drive(1'b1, BIT);
    n_cmp++; if (v_rise - v0 !== 0) begin n_bad++; $display("FAIL midreset_false_byte got %0d want 0", v_rise - v0); end
    n_cmp++; if (fe_rise - fe0 !== 0) begin n_bad++; $display("FAIL midreset_frame_err got %0d want 0", fe_rise - fe0); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset_idle got %b want 0", busy); end
    exp_q.push_back(8'h69);
    send_frame(8'h69, 1'b1);
    drive(1'b1, BIT);
    wait_obs(1, ok);
    n_cmp++; if (!ok || obs_q.size() != 1) begin n_bad++; $display("FAIL midreset_next_count got %0d want 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL midreset_next_data got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_framing;
    test_overrun;
    test_reset_midframe;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
